hazard_sequencer: RTL and testbench

- Pipeline control for the 5-stage MIPS core; sits beside forwarding_unit.
- Detects load-use hazards, memory waits and taken branches/jumps.
- Drives per-latch enable/flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Holds a small FSM for branch refill and data-memory wait, plus a watchdog counter on stuck data accesses.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/hazard_sequencer_if.sv | 46 ++++
 rtl/hazard_watchdog.sv | 42 ++++
 rtl/hazard_sequencer.sv | 139 +++++++++++++
 tb/tb_hazard_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage MIPS pipeline control blocks.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        REFILL = 2'd2
    } hz_state_t;

    localparam logic [5:0] LW = 6'h23;

    function automatic logic [5:0] opcode_of(input word_t instr);
        return instr[31:26];
    endfunction

    function automatic regbits_t rs_of(input word_t instr);
        return instr[25:21];
    endfunction

    function automatic regbits_t rt_of(input word_t instr);
        return instr[20:16];
    endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Bundle of hazard_sequencer connections; hs is the sequencer side, tb the driver side.
// Performance counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_sequencer_if;
    import cpu_types_pkg::*;

    logic  RST;
    word_t imemload_id;
    word_t imemload_exe;
    logic  ihit;
    logic  dhit;
    logic  dmemREN_mem;
    logic  dmemWEN_mem;
    logic  pcsrc_mem;
    logic  pc_en;
    logic  ifid_en;
    logic  ifid_flush;
    logic  idex_en;
    logic  idex_flush;
    logic  exmem_en;
    logic  exmem_flush;
    logic  memwb_en;
    logic  hang_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    modport hs (
        input  RST, imemload_id, imemload_exe, ihit, dhit, dmemREN_mem, dmemWEN_mem, pcsrc_mem,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cycles, flush_count,
`endif
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en,
               hang_err
    );

    modport tb (
        output RST, imemload_id, imemload_exe, ihit, dhit, dmemREN_mem, dmemWEN_mem, pcsrc_mem,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cycles, flush_count,
`endif
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en,
               hang_err
    );

endinterface

// File: rtl/hazard_watchdog.sv
// Saturating stuck-access counter with a sticky hang flag, cleared only by reset.
module hazard_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic en_i,
    input  logic clr_i,
    output logic hang_err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;
    logic          hang_q, hang_d;

    always_comb begin
        count_d = count_q;
        hang_d  = hang_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (count_q == CW'(TIMEOUT)) begin
                hang_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
            hang_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            hang_q  <= hang_d;
        end
    end

    assign hang_err_o = hang_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush control: load-use, data-memory wait, branch refill and watchdog.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles / flush_count counters.
module hazard_sequencer
    import cpu_types_pkg::*;
#(
    parameter int         TIMEOUT = 255,
    parameter logic [5:0] LW_OP   = LW
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] imemload_id,
    input  logic [31:0] imemload_exe,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dmemREN_mem,
    input  logic        dmemWEN_mem,
    input  logic        pcsrc_mem,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        exmem_flush,
    output logic        memwb_en,
    output logic        hang_err
);

    hz_state_t state_q, state_d;
    hz_state_t ret_q, ret_d;
    hz_state_t eff_state;
    regbits_t  rs_id, rt_id, rt_exe;
    logic      mem_busy;
    logic      lu_hazard;

    assign rs_id     = rs_of(imemload_id);
    assign rt_id     = rt_of(imemload_id);
    assign rt_exe    = rt_of(imemload_exe);
    assign mem_busy  = (dmemREN_mem | dmemWEN_mem) & ~dhit;
    assign lu_hazard = (opcode_of(imemload_exe) == LW_OP) && (rt_exe != '0)
                       && ((rt_exe == rs_id) || (rt_exe == rt_id));

    // The dhit cycle leaving DWAIT is judged by the rules of the state it interrupted.
    assign eff_state = (state_q == DWAIT) ? ret_q : state_q;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        state_d     = RUN;
        ret_d       = ret_q;
        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            memwb_en    = 1'b0;
            ret_d       = RUN;
        end else if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = DWAIT;
            ret_d    = eff_state;
        end else if (eff_state == REFILL) begin
            pc_en      = ihit;
            ifid_flush = ~ihit;
            state_d    = ihit ? RUN : REFILL;
        end else if (pcsrc_mem) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = REFILL;
        end else if (lu_hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            ret_q   <= RUN;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end

    hazard_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .CLK        (CLK),
        .RST        (RST),
        .en_i       (mem_busy),
        .clr_i      (~mem_busy),
        .hang_err_o (hang_err)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;
    logic        flush_evt;

    assign flush_evt = ~RST & ~mem_busy & (eff_state != REFILL) & pcsrc_mem;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en) stall_q <= stall_q + 32'd1;
            if (flush_evt) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

    logic unused_bits;
    assign unused_bits = ^{imemload_id[15:0], imemload_exe[25:21], imemload_exe[15:0]};

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized and directed check of hazard_sequencer against a rule-level reference model.
module tb_hazard_sequencer;
    import cpu_types_pkg::*;

    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    hazard_sequencer_if u_if ();

    hazard_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .CLK          (clk),
        .RST          (u_if.RST),
        .imemload_id  (u_if.imemload_id),
        .imemload_exe (u_if.imemload_exe),
        .ihit         (u_if.ihit),
        .dhit         (u_if.dhit),
        .dmemREN_mem  (u_if.dmemREN_mem),
        .dmemWEN_mem  (u_if.dmemWEN_mem),
        .pcsrc_mem    (u_if.pcsrc_mem),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles (u_if.stall_cycles),
        .flush_count  (u_if.flush_count),
`endif
        .pc_en        (u_if.pc_en),
        .ifid_en      (u_if.ifid_en),
        .ifid_flush   (u_if.ifid_flush),
        .idex_en      (u_if.idex_en),
        .idex_flush   (u_if.idex_flush),
        .exmem_en     (u_if.exmem_en),
        .exmem_flush  (u_if.exmem_flush),
        .memwb_en     (u_if.memwb_en),
        .hang_err     (u_if.hang_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: are we still waiting for the refetch after a branch,
    // how long the current data access has been stuck, and the sticky flag.
    bit m_refill = 1'b0;
    int m_wait   = 0;
    bit m_hang   = 1'b0;
    int m_stalls = 0;
    int m_flushes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic word_t lw_instr(input int rs, input int rt);
        return {6'h23, 5'(rs), 5'(rt), 16'h0004};
    endfunction

    function automatic word_t r_instr(input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 11'h020};
    endfunction

    // Output vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en
    task automatic step(input bit rst, input word_t id, input word_t exe, input bit ih,
                        input bit dh, input bit rn, input bit wn, input bit pc);
        logic [7:0] exp_v;
        logic [7:0] obs_v;
        bit busy;
        bit lu;
        int rt_e;
        u_if.RST          = rst;
        u_if.imemload_id  = id;
        u_if.imemload_exe = exe;
        u_if.ihit         = ih;
        u_if.dhit         = dh;
        u_if.dmemREN_mem  = rn;
        u_if.dmemWEN_mem  = wn;
        u_if.pcsrc_mem    = pc;
        @(negedge clk);
        busy = (rn || wn) && !dh;
        rt_e = int'(exe[20:16]);
        lu   = (exe[31:26] == 6'h23) && rt_e != 0
               && (rt_e == int'(id[25:21]) || rt_e == int'(id[20:16]));
        if (rst)           exp_v = 8'b0010_1010;
        else if (busy)     exp_v = 8'b0000_0000;
        else if (m_refill) exp_v = {ih, 1'b1, !ih, 5'b1_0101};
        else if (pc)       exp_v = 8'b1111_1111;
        else if (lu)       exp_v = 8'b0001_1101;
        else if (!ih)      exp_v = 8'b0111_0101;
        else               exp_v = 8'b1101_0101;
        obs_v = {u_if.pc_en, u_if.ifid_en, u_if.ifid_flush, u_if.idex_en, u_if.idex_flush,
                 u_if.exmem_en, u_if.exmem_flush, u_if.memwb_en};
        chk("latch_ctrl", 32'(obs_v), 32'(exp_v));
        chk("hang_err", 32'(u_if.hang_err), 32'(m_hang));
        if (rst) begin
            m_refill = 1'b0;
            m_wait   = 0;
            m_hang   = 1'b0;
            m_stalls = 0;
            m_flushes = 0;
        end else begin
            if (!exp_v[7]) m_stalls++;
            if (busy) begin
                if (m_wait >= TIMEOUT) m_hang = 1'b1;
                m_wait = (m_wait + 1 > TIMEOUT) ? TIMEOUT : m_wait + 1;
            end else begin
                m_wait = 0;
                if (m_refill) m_refill = !ih;
                else if (pc) begin
                    m_refill = 1'b1;
                    m_flushes++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, r_instr(1, 2, 3), r_instr(4, 6, 7), 1, 1, 0, 0, 0);
    endtask

    initial begin
        word_t nop;
        word_t id_w, exe_w;
        nop = '0;
        @(posedge clk);
        #1;
        step(1, nop, nop, 1, 1, 0, 0, 0);
        step(1, nop, nop, 0, 0, 1, 0, 1);
        idle(2);

        // load-use: one bubble then flow
        step(0, r_instr(5, 2, 3), lw_instr(1, 5), 1, 1, 0, 0, 0);
        step(0, r_instr(5, 2, 3), nop, 1, 1, 0, 0, 0);
        // load-use through rt, with a simultaneous imem miss
        step(0, r_instr(2, 5, 3), lw_instr(1, 5), 0, 1, 0, 0, 0);
        // load into $0 never stalls
        step(0, r_instr(0, 0, 3), lw_instr(1, 0), 1, 1, 0, 0, 0);

        // three-cycle data wait, released by dhit
        for (int i = 0; i < 3; i++) step(0, nop, nop, 1, 0, 1, 0, 0);
        step(0, nop, nop, 1, 1, 1, 0, 0);
        chk("wait_no_hang", 32'(u_if.hang_err), 32'd0);

        // watchdog: six stuck store cycles
        for (int i = 0; i < 6; i++) step(0, nop, nop, 1, 0, 0, 1, 0);
        step(0, nop, nop, 1, 1, 0, 1, 0);
        idle(3);
        chk("hang_sticky", 32'(u_if.hang_err), 32'd1);
        step(1, nop, nop, 1, 1, 0, 0, 0);
        chk("hang_cleared", 32'(u_if.hang_err), 32'd0);

        // exactly TIMEOUT stuck cycles must not trip the flag
        for (int i = 0; i < TIMEOUT; i++) step(0, nop, nop, 1, 0, 1, 0, 0);
        step(0, nop, nop, 1, 1, 1, 0, 0);
        chk("hang_boundary", 32'(u_if.hang_err), 32'd0);

        // branch with a two-cycle refetch miss
        step(0, nop, nop, 0, 1, 0, 0, 1);
        step(0, nop, nop, 0, 1, 0, 0, 0);
        step(0, nop, nop, 0, 1, 0, 0, 1);
        step(0, nop, nop, 1, 1, 0, 0, 0);
        idle(1);

        // data wait interrupting a refill resumes the refill
        step(0, nop, nop, 1, 1, 0, 0, 1);
        step(0, nop, nop, 0, 0, 1, 0, 0);
        step(0, nop, nop, 0, 0, 1, 0, 0);
        step(0, nop, nop, 0, 1, 1, 0, 0);
        step(0, r_instr(5, 2, 3), lw_instr(1, 5), 1, 1, 0, 0, 0);
        idle(1);

        // reset in the middle of a data wait
        step(0, nop, nop, 1, 0, 1, 0, 0);
        step(0, nop, nop, 1, 0, 1, 0, 0);
        step(1, nop, nop, 1, 0, 1, 0, 0);
        step(0, r_instr(1, 2, 3), nop, 0, 1, 0, 0, 0);
        idle(1);

        // reset in the middle of a refill
        step(0, nop, nop, 0, 1, 0, 0, 1);
        step(1, nop, nop, 0, 1, 0, 0, 0);
        step(0, nop, nop, 0, 1, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_ih, r_dh, r_rn, r_wn, r_pc;
            r_rst = ($urandom_range(0, 99) == 0);
            r_ih  = ($urandom_range(0, 3) != 0);
            r_dh  = ($urandom_range(0, 9) < 6);
            r_rn  = ($urandom_range(0, 4) == 0);
            r_wn  = ($urandom_range(0, 6) == 0);
            r_pc  = ($urandom_range(0, 7) == 0);
            id_w  = r_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                exe_w = lw_instr($urandom_range(0, 31), $urandom_range(0, 3));
            else
                exe_w = r_instr($urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) begin
                // long stuck access to reach the watchdog
                for (int k = 0; k < 7; k++) step(0, id_w, exe_w, r_ih, 0, 1, 0, r_pc);
            end
            step(r_rst, id_w, exe_w, r_ih, r_dh, r_rn, r_wn, r_pc);
        end

`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        chk("stall_cycles", u_if.stall_cycles, 32'(m_stalls));
        chk("flush_count", u_if.flush_count, 32'(m_flushes));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
